// File: rtl/ms72xx_pkg.sv
// rtl/ms72xx_pkg.sv - shared constants, register tables and state types for the MS72xx config controller
package ms72xx_pkg;

  localparam logic [7:0] RX_DEV = 8'h56;
  localparam logic [7:0] TX_DEV = 8'hB2;

  localparam int RX_NUM = 4;
  localparam int TX_NUM = 4;
  localparam int IDX_W  = 2;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } cfg_entry_t;

  localparam cfg_entry_t RX_TABLE [RX_NUM] = '{
    {16'h0003, 8'h30},
    {16'h0004, 8'h01},
    {16'h0005, 8'h81},
    {16'h0094, 8'h02}
  };

  localparam cfg_entry_t TX_TABLE [TX_NUM] = '{
    {16'h0003, 8'h10},
    {16'h0004, 8'h01},
    {16'h0066, 8'hF3},
    {16'h0099, 8'h08}
  };

  typedef enum logic [1:0] {
    SEQ_WAIT,
    SEQ_RX,
    SEQ_TX,
    SEQ_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_START,
    PH_BITS,
    PH_STOP,
    PH_GAP
  } i2c_phase_t;

endpackage

// File: rtl/ms72xx_ctrl_i2c_wr_engine.sv
// rtl/ms72xx_ctrl_i2c_wr_engine.sv - four-byte I2C write engine (dev, reg hi, reg lo, data) on quarter-period ticks
module i2c_wr_engine
  import ms72xx_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  dev,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  data,
  input  logic        sda_in,
  output logic        busy,
  output logic        done,
  output logic        nack,
  output logic        scl_o,
  output logic        sda_oe
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  i2c_phase_t    phase, phase_n;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   shreg;
  logic [1:0]    sda_sync;
  logic          tick, q_last, ack_bit;

  assign tick    = (div_cnt == DW'(CLK_DIV - 1));
  assign q_last  = tick && (q == 2'd3);
  assign ack_bit = (bit_cnt == 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= PH_IDLE;
    else     phase <= phase_n;
  end

  always_comb begin
    phase_n = phase;
    case (phase)
      PH_IDLE:  if (start) phase_n = PH_START;
      PH_START: if (q_last) phase_n = PH_BITS;
      PH_BITS:  if (q_last && ack_bit && byte_cnt == 2'd3) phase_n = PH_STOP;
      PH_STOP:  if (q_last) phase_n = PH_GAP;
      PH_GAP:   if (q_last) phase_n = PH_IDLE;
      default:  phase_n = PH_IDLE;
    endcase
  end

  // A NACK is latched but the frame still runs to STOP; the sequencer decides on retry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      q        <= 2'd0;
      bit_cnt  <= 4'd0;
      byte_cnt <= 2'd0;
      shreg    <= 32'd0;
      sda_sync <= 2'b11;
      nack     <= 1'b0;
      done     <= 1'b0;
    end else begin
      sda_sync <= {sda_sync[0], sda_in};
      done     <= (phase == PH_STOP) && q_last;
      if (phase == PH_IDLE) begin
        div_cnt  <= '0;
        q        <= 2'd0;
        bit_cnt  <= 4'd0;
        byte_cnt <= 2'd0;
        if (start) begin
          shreg <= {dev, reg_addr, data};
          nack  <= 1'b0;
        end
      end else if (tick) begin
        div_cnt <= '0;
        q       <= q + 2'd1;
        if (phase == PH_BITS && ack_bit && q == 2'd2 && sda_sync[1]) nack <= 1'b1;
        if (phase == PH_BITS && q == 2'd3) begin
          if (ack_bit) begin
            bit_cnt  <= 4'd0;
            byte_cnt <= byte_cnt + 2'd1;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= {shreg[30:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_comb begin
    busy   = (phase != PH_IDLE);
    scl_o  = 1'b1;
    sda_oe = 1'b0;
    case (phase)
      PH_START: begin
        scl_o  = (q != 2'd3);
        sda_oe = (q != 2'd0);
      end
      PH_BITS: begin
        scl_o  = q[1];
        sda_oe = !ack_bit && !shreg[31];
      end
      PH_STOP: begin
        scl_o  = (q != 2'd0);
        sda_oe = !q[1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ms72xx_ctrl.sv
// rtl/ms72xx_ctrl.sv - power-up sequencer writing the MS7200 then MS7210 register tables over I2C
module ms72xx_ctrl
  import ms72xx_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int STARTUP_DLY = 10000
) (
  input  logic clk,
  input  logic rst,
  output logic init_over,
  output logic iic_scl,
  inout  wire  iic_sda,
  output logic iic_tx_scl,
  inout  wire  iic_tx_sda
);

  seq_state_t       state, state_n;
  logic [31:0]      wait_cnt;
  logic [IDX_W-1:0] idx;
  logic             sel_tx, start, entry_ok, last_entry;
  logic             eng_busy, eng_done, eng_nack, eng_scl, eng_oe;
  logic [7:0]       cur_dev;
  cfg_entry_t       cur;

  assign entry_ok   = eng_done && !eng_nack && (state == SEQ_RX || state == SEQ_TX);
  assign last_entry = (state == SEQ_TX) ? (idx == IDX_W'(TX_NUM - 1)) : (idx == IDX_W'(RX_NUM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEQ_WAIT;
      wait_cnt <= 32'd0;
      idx      <= '0;
    end else begin
      state <= state_n;
      if (state == SEQ_WAIT) wait_cnt <= wait_cnt + 32'd1;
      if (entry_ok) idx <= last_entry ? '0 : idx + IDX_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      SEQ_WAIT: if (wait_cnt == 32'(STARTUP_DLY - 1)) state_n = SEQ_RX;
      SEQ_RX:   if (entry_ok && last_entry) state_n = SEQ_TX;
      SEQ_TX:   if (entry_ok && last_entry) state_n = SEQ_DONE;
      default:  state_n = state;
    endcase
  end

  // Start is held while the engine is busy; the engine only accepts it from idle.
  always_comb begin
    sel_tx    = (state == SEQ_TX);
    start     = (state == SEQ_RX) || (state == SEQ_TX);
    init_over = (state == SEQ_DONE);
    cur       = sel_tx ? TX_TABLE[idx] : RX_TABLE[idx];
    cur_dev   = sel_tx ? TX_DEV : RX_DEV;
  end

  i2c_wr_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dev      (cur_dev),
    .reg_addr (cur.addr),
    .data     (cur.data),
    .sda_in   (sel_tx ? iic_tx_sda : iic_sda),
    .busy     (eng_busy),
    .done     (eng_done),
    .nack     (eng_nack),
    .scl_o    (eng_scl),
    .sda_oe   (eng_oe)
  );

  assign iic_scl    = sel_tx ? 1'b1 : eng_scl;
  assign iic_tx_scl = sel_tx ? eng_scl : 1'b1;
  assign iic_sda    = (!sel_tx && eng_oe) ? 1'b0 : 1'bz;
  assign iic_tx_sda = (sel_tx && eng_oe) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ms72xx_ctrl.sv
// tb/tb_ms72xx_ctrl.sv - scoreboard bench: I2C slave/decoder monitor on both buses against hand-written tables
module tb_ms72xx_ctrl;

  localparam int CDIV = 2;
  localparam int SDLY = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_over, iic_scl, iic_tx_scl;
  wire  iic_sda, iic_tx_sda;
  logic [1:0] drv = 2'b00;

  pullup (iic_sda);
  pullup (iic_tx_sda);
  assign iic_sda    = drv[0] ? 1'b0 : 1'bz;
  assign iic_tx_sda = drv[1] ? 1'b0 : 1'bz;

  ms72xx_ctrl #(.CLK_DIV(CDIV), .STARTUP_DLY(SDLY)) dut (
    .clk        (clk),
    .rst        (rst),
    .init_over  (init_over),
    .iic_scl    (iic_scl),
    .iic_sda    (iic_sda),
    .iic_tx_scl (iic_tx_scl),
    .iic_tx_sda (iic_tx_sda)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Hand-derived frames: {device byte, reg hi, reg lo, data}
  logic [31:0] rx_exp [4] = '{32'h56_00_03_30, 32'h56_00_04_01, 32'h56_00_05_81, 32'h56_00_94_02};
  logic [31:0] tx_exp [4] = '{32'hB2_00_03_10, 32'hB2_00_04_01, 32'hB2_00_66_F3, 32'hB2_00_99_08};
  logic [32:0] exp_q [$];

  int   nack_until = 0;
  int   rx_starts = 0;
  int   both_active = 0;
  int   stray_stop = 0;
  int   init_rises = 0;
  logic pinit = 1'b0;
  logic [1:0] pscl = 2'b11, psda = 2'b11, scl_v, sda_v;
  bit   in_frame [2];
  bit   first_fall [2];
  bit   have_stop [2];
  bit   nack_txn [2];
  int   bitc [2];
  int   byten [2];
  int   start_cyc [2];
  int   last_rise [2];
  int   last_stop [2];
  logic [7:0]  shf [2];
  logic [31:0] got [2];
  logic [5:0]  txn_err [2];

  // Monitor: decodes both buses at negedge, acts as ACKing slave, pops the scoreboard on STOP.
  always @(negedge clk) begin
    scl_v = {iic_tx_scl, iic_scl};
    sda_v = {iic_tx_sda, iic_sda};
    if (rst) begin
      drv = 2'b00;
      for (int b = 0; b < 2; b++) begin
        in_frame[b] = 0;
        bitc[b] = 0;
        byten[b] = 0;
      end
    end else begin
      if ((!scl_v[0] || !sda_v[0]) && (!scl_v[1] || !sda_v[1])) both_active++;
      if (init_over && !pinit) begin
        init_rises++;
        check("init_rise_delay", 64'(cyc - last_stop[1]), 64'(2 * CDIV + 1));
      end
      for (int b = 0; b < 2; b++) begin
        if (scl_v[b] && pscl[b] && psda[b] && !sda_v[b]) begin
          txn_err[b] = in_frame[b] ? 6'd1 : 6'd0;
          if (have_stop[b] && (cyc - last_stop[b]) < 4 * CDIV) txn_err[b] |= 6'd2;
          in_frame[b] = 1;
          first_fall[b] = 1;
          bitc[b] = 0;
          byten[b] = 0;
          got[b] = 32'd0;
          start_cyc[b] = cyc;
          last_rise[b] = -1;
          if (b == 0) begin
            nack_txn[b] = (rx_starts < nack_until);
            rx_starts++;
          end else begin
            nack_txn[b] = 0;
          end
        end else if (scl_v[b] && pscl[b] && !psda[b] && sda_v[b]) begin
          if (!in_frame[b]) begin
            stray_stop++;
          end else begin
            if (byten[b] != 4 || bitc[b] != 0) txn_err[b] |= 6'd4;
            if ((cyc - last_rise[b]) < CDIV) txn_err[b] |= 6'd8;
            if (exp_q.size() == 0) check("unexpected_txn", {b[0], got[b]}, 33'd0);
            else check("txn", {b[0], got[b]}, exp_q.pop_front());
            check("proto", 64'(txn_err[b]), 64'd0);
            check("init_low_during_txn", 64'(init_over), 64'd0);
            in_frame[b] = 0;
            last_stop[b] = cyc;
            have_stop[b] = 1;
          end
        end else if (in_frame[b] && scl_v[b] && !pscl[b]) begin
          if (byten[b] < 4) begin
            if (last_rise[b] >= 0 && (cyc - last_rise[b]) != 4 * CDIV) txn_err[b] |= 6'd16;
            if (bitc[b] < 8) begin
              shf[b] = {shf[b][6:0], sda_v[b]};
              bitc[b]++;
              if (bitc[b] == 8) got[b] = {got[b][23:0], shf[b]};
            end else begin
              bitc[b] = 0;
              byten[b]++;
            end
          end
          last_rise[b] = cyc;
        end else if (in_frame[b] && !scl_v[b] && pscl[b]) begin
          if (first_fall[b] && (cyc - start_cyc[b]) < CDIV) txn_err[b] |= 6'd32;
          first_fall[b] = 0;
          drv[b] = (bitc[b] == 8) && !nack_txn[b];
        end
      end
    end
    pscl = scl_v;
    psda = sda_v;
    pinit = init_over;
  end

  task automatic push_full_sequence();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, rx_exp[i]});
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, tx_exp[i]});
  endtask

  task automatic release_and_measure(input string tag);
    int   n;
    logic idle_ok;
    idle_ok = 1'b1;
    rst = 1'b0;
    for (n = 1; n <= SDLY + 64; n++) begin
      @(negedge clk);
      if (iic_sda == 1'b0) break;
      if (!(iic_scl && iic_tx_scl && iic_tx_sda)) idle_ok = 1'b0;
    end
    check({tag, "_wait_idle"}, 64'(idle_ok), 64'd1);
    check_range({tag, "_first_start_cycle"}, n, SDLY + 1, SDLY + 4 * CDIV);
  endtask

  task automatic wait_init_and_idle(input string tag);
    int   n;
    int   r0;
    logic ok;
    r0 = init_rises;
    for (n = 0; n < 20000 && !init_over; n++) @(negedge clk);
    check({tag, "_init_over"}, 64'(init_over), 64'd1);
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (!(init_over && iic_scl && iic_sda && iic_tx_scl && iic_tx_sda)) ok = 1'b0;
    end
    check({tag, "_idle_after_done"}, 64'(ok), 64'd1);
    check({tag, "_init_rises"}, 64'(init_rises - r0), 64'd1);
  endtask

  initial begin
    int   n;
    logic pre_sda;
    rst = 1'b1;
    nack_until = 2;
    repeat (3) @(negedge clk);
    check("reset_init_over", 64'(init_over), 64'd0);
    check("reset_bus", 64'({iic_scl, iic_sda, iic_tx_scl, iic_tx_sda}), 64'hF);

    // Two NACKed attempts of RX entry 0 precede the successful one.
    exp_q.push_back({1'b0, rx_exp[0]});
    exp_q.push_back({1'b0, rx_exp[0]});
    push_full_sequence();
    release_and_measure("run1");
    wait_init_and_idle("run1");
    check("run1_queue_drained", 64'(exp_q.size()), 64'd0);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rerst_init_over", 64'(init_over), 64'd0);
    release_and_measure("run2");
    for (n = 0; n < 2000; n++) begin
      if (in_frame[0] && byten[0] == 2 && bitc[0] == 3) break;
      @(negedge clk);
    end
    check("reach_mid_byte", 64'(n < 2000), 64'd1);
    pre_sda = iic_sda;
    check("pre_abort_sda_low", 64'(pre_sda), 64'd0);
    #2 rst = 1'b1;
    #1 check("async_abort_bus", 64'({iic_scl, iic_sda, iic_tx_scl, iic_tx_sda}), 64'hF);
    repeat (3) @(negedge clk);

    push_full_sequence();
    release_and_measure("run3");
    wait_init_and_idle("run3");
    check("run3_queue_drained", 64'(exp_q.size()), 64'd0);
    check("inactive_bus_quiet", 64'(both_active), 64'd0);
    check("stray_stop", 64'(stray_stop), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
